nibble_serial_adder_ctrl: RTL

//  Multi-cycle controller that adds two WIDTH*NUM_WORDS-bit operands with one

---
 rtl/nibble_serial_adder_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH*NUM_WORDS-bit operands through one external WIDTH-bit adder.
// The operands are fed in one word per cycle, least significant word first.
// The carry out of each word is fed back in as the carry-in of the next word.
// The block collects the sum words and reports the final carry and the signed
// overflow together with a one-cycle done pulse.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH     = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH*NUM_WORDS-1:0]   op_a,
  input  logic [WIDTH*NUM_WORDS-1:0]   op_b,
  input  logic                         cin,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH*NUM_WORDS-1:0]   result,
  output logic                         cout,
  output logic                         ovf,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  output logic                         add_cin,
  input  logic [WIDTH-1:0]             add_sum,
  input  logic                         add_cout
);

  localparam int W  = WIDTH * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_s;
  logic [WIDTH-1:0] add_a_s, add_b_s;
  logic            add_cin_s;

  // Next-state, datapath update and adder drive for the current word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    accept_s  = 1'b0;
    add_a_s   = {WIDTH{1'b0}};
    add_b_s   = {WIDTH{1'b0}};
    add_cin_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        add_a_s   = a_q[cnt_q*WIDTH +: WIDTH];
        add_b_s   = b_q[cnt_q*WIDTH +: WIDTH];
        add_cin_s = (cnt_q == {CW{1'b0}}) ? cin_q : carry_q;
        result_d[cnt_q*WIDTH +: WIDTH] = add_sum;
        carry_d   = add_cout;
        if (cnt_q == LAST_CNT) begin
          // Last word: the adder's MSB and carry give the final flags.
          state_d = ST_DONE;
          cnt_d   = {CW{1'b0}};
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[WIDTH-1] != a_q[W-1]);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // A new request is latched only while the block can accept it.
    if (accept_s) begin
      a_d   = op_a;
      b_d   = op_b;
      cin_d = cin;
      cnt_d = {CW{1'b0}};
    end else begin
      a_d   = a_d;
      b_d   = b_d;
      cin_d = cin_d;
    end

    ready_d = (state_d != ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= {W{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign add_a   = add_a_s;
  assign add_b   = add_b_s;
  assign add_cin = add_cin_s;

endmodule
